// File: rtl/vga_timing_pkg.sv
// Timing constants and region helpers shared by the VGA timing generator slice.
// Holds 720x480@60 (27 MHz) defaults and a 640x480@60 set for 25 MHz boards.
package vga_timing_pkg;

  // 720x480@60, 27 MHz pixel clock: 858 x 525 total
  localparam int H720_DISPLAY = 720;
  localparam int H720_FRONT   = 16;
  localparam int H720_SYNC    = 62;
  localparam int H720_BACK    = 60;
  localparam int V480_DISPLAY = 480;
  localparam int V480_FRONT   = 9;
  localparam int V480_SYNC    = 6;
  localparam int V480_BACK    = 30;

  // 640x480@60, 25.175 MHz pixel clock (25 MHz boards are close enough): 800 x 525 total
  localparam int H640_DISPLAY = 640;
  localparam int H640_FRONT   = 16;
  localparam int H640_SYNC    = 96;
  localparam int H640_BACK    = 48;
  localparam int V640_DISPLAY = 480;
  localparam int V640_FRONT   = 10;
  localparam int V640_SYNC    = 2;
  localparam int V640_BACK    = 33;

  typedef enum logic [1:0] {
    REGION_ACTIVE,
    REGION_FRONT,
    REGION_SYNC,
    REGION_BACK
  } region_t;

  // Classifies a line/frame position; the same function serves both axes.
  function automatic region_t region_of(input int cnt, input int disp,
                                        input int front, input int sync);
    if (cnt < disp)
      return REGION_ACTIVE;
    else if (cnt < disp + front)
      return REGION_FRONT;
    else if (cnt < disp + front + sync)
      return REGION_SYNC;
    else
      return REGION_BACK;
  endfunction

endpackage

// File: rtl/vga_pixel_strobe.sv
// Divides the system clock into pixel periods of CLK_DIV clocks each.
// pix_first marks the first clock of a pixel period, pix_last the final one.
module vga_pixel_strobe
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic pix_first,
  output logic pix_last
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  assign pix_first = (div_cnt == '0);
  assign pix_last  = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)
      div_cnt <= '0;
    else if (pix_last)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/position timing generator; produces timing only, colour mapping lives in the board top.
// Define VGA_FRAME_COUNT_EN to add the 8-bit frame_num output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H720_DISPLAY,
  parameter int H_FRONT   = H720_FRONT,
  parameter int H_SYNC    = H720_SYNC,
  parameter int H_BACK    = H720_BACK,
  parameter int V_DISPLAY = V480_DISPLAY,
  parameter int V_FRONT   = V480_FRONT,
  parameter int V_SYNC    = V480_SYNC,
  parameter int V_BACK    = V480_BACK,
  parameter int CLK_DIV   = 1
) (
  input  logic clk,
  input  logic rst,
  output logic hsync,
  output logic vsync,
  output logic display_on,
  output logic [$clog2(H_DISPLAY+H_FRONT+H_SYNC+H_BACK)-1:0] x,
  output logic [$clog2(V_DISPLAY+V_FRONT+V_SYNC+V_BACK)-1:0] y,
  output logic pixel_stb
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_num
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           pix_first;
  logic           pix_last;
  logic           h_wrap;
  logic           v_wrap;
  region_t        h_region;
  region_t        v_region;

  vga_pixel_strobe #(
    .CLK_DIV(CLK_DIV)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .pix_first(pix_first),
    .pix_last (pix_last)
  );

  assign h_wrap = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == V_W'(V_TOTAL - 1));

  // Counters step at the end of each pixel period so every pixel lasts CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_last) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  always_comb begin
    h_region = region_of(int'(h_cnt), H_DISPLAY, H_FRONT, H_SYNC);
    v_region = region_of(int'(v_cnt), V_DISPLAY, V_FRONT, V_SYNC);
  end

  // Every output is registered from the same counter state so all of them lag by one clock together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      display_on <= 1'b0;
      x          <= '0;
      y          <= '0;
      pixel_stb  <= 1'b0;
    end else begin
      hsync      <= (h_region != REGION_SYNC);
      vsync      <= (v_region != REGION_SYNC);
      display_on <= (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE);
      x          <= h_cnt;
      y          <= v_cnt;
      pixel_stb  <= pix_first;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt;

  // frame_cnt tracks the counters; frame_num is delayed one clock to stay aligned with x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      frame_num <= '0;
    end else begin
      if (pix_last && h_wrap && v_wrap)
        frame_cnt <= frame_cnt + 8'd1;
      frame_num <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, CLK_DIV=2 and a reduced-size frame.
// Frame-number checks are built when VGA_FRAME_COUNT_EN is defined.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       hs0, vs0, de0, stb0;
  logic [9:0] x0, y0;
  logic       hs2, vs2, de2, stb2;
  logic [9:0] x2, y2;
  logic       hss, vss, des, stbs;
  logic [3:0] xs;
  logic [2:0] ys;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fn0, fn2, fns;
`endif

  vga_timing_gen dut (
    .clk(clk), .rst(rst), .hsync(hs0), .vsync(vs0), .display_on(de0),
    .x(x0), .y(y0), .pixel_stb(stb0)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_num(fn0)
`endif
  );

  vga_timing_gen #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .hsync(hs2), .vsync(vs2), .display_on(de2),
    .x(x2), .y(y2), .pixel_stb(stb2)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_num(fn2)
`endif
  );

  // 15 x 8 totals: 120 clocks per frame keeps vertical and frame behaviour cheap to reach
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)
  ) dut_s (
    .clk(clk), .rst(rst), .hsync(hss), .vsync(vss), .display_on(des),
    .x(xs), .y(ys), .pixel_stb(stbs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_num(fns)
`endif
  );

  typedef struct {
    int k;
    int inst;
    bit hs;
    bit vs;
    bit de;
    int x;
    int y;
    bit stb;
    int fn;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  int run0, len0, fall0, per0, de0_cnt;
  int run2, len2, fall2, per2, stb2_cnt, stb_err, hold_err;
  int runs, lens, falls, pers, des_frame, des_err;
  logic p_hs0, p_hs2, p_vss;
  logic [22:0] p_out2;

  function automatic vec_t mk(input int k, input int inst, input bit hs, input bit vs,
                              input bit de, input int x, input int y, input bit stb,
                              input int fn);
    vec_t v;
    v.k = k; v.inst = inst; v.hs = hs; v.vs = vs; v.de = de;
    v.x = x; v.y = y; v.stb = stb; v.fn = fn;
    return v;
  endfunction

  function automatic logic [63:0] pack(input logic hs, input logic vs, input logic de,
                                       input logic stb, input int x, input int y);
    return {28'd0, hs, vs, de, stb, x[15:0], y[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    @(negedge clk);
    cyc = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_dut"},   pack(hs0, vs0, de0, stb0, int'(x0), int'(y0)), pack(1, 1, 0, 0, 0, 0));
    checkOutput({tag, "_div2"},  pack(hs2, vs2, de2, stb2, int'(x2), int'(y2)), pack(1, 1, 0, 0, 0, 0));
    checkOutput({tag, "_small"}, pack(hss, vss, des, stbs, int'(xs), int'(ys)), pack(1, 1, 0, 0, 0, 0));
`ifdef VGA_FRAME_COUNT_EN
    checkOutput({tag, "_frame"}, 64'({fn0, fn2, fns}), 64'(0));
`endif
  endtask

  task automatic runTable(input string tag);
    logic [63:0] act;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].k);
      case (vecs[i].inst)
        0:       act = pack(hs0, vs0, de0, stb0, int'(x0), int'(y0));
        1:       act = pack(hs2, vs2, de2, stb2, int'(x2), int'(y2));
        default: act = pack(hss, vss, des, stbs, int'(xs), int'(ys));
      endcase
      checkOutput($sformatf("%s_vec%0d_k%0d", tag, i, vecs[i].k), act,
                  pack(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].stb, vecs[i].x, vecs[i].y));
`ifdef VGA_FRAME_COUNT_EN
      if (vecs[i].inst == 2)
        checkOutput($sformatf("%s_frame%0d_k%0d", tag, i, vecs[i].k), 64'(fns), 64'(vecs[i].fn));
`endif
    end
  endtask

  initial begin
    // k = clocks since reset release; fields: k, inst(0 dut,1 div2,2 small), hs, vs, de, x, y, stb, frame
    vecs.push_back(mk(0,    0, 1, 1, 1, 0,   0, 1, 0));
    vecs.push_back(mk(0,    1, 1, 1, 1, 0,   0, 1, 0));
    vecs.push_back(mk(0,    2, 1, 1, 1, 0,   0, 1, 0));
    vecs.push_back(mk(1,    1, 1, 1, 1, 0,   0, 0, 0));
    vecs.push_back(mk(2,    1, 1, 1, 1, 1,   0, 1, 0));
    vecs.push_back(mk(7,    2, 1, 1, 1, 7,   0, 1, 0));
    vecs.push_back(mk(8,    2, 1, 1, 0, 8,   0, 1, 0));
    vecs.push_back(mk(10,   2, 0, 1, 0, 10,  0, 1, 0));
    vecs.push_back(mk(12,   2, 0, 1, 0, 12,  0, 1, 0));
    vecs.push_back(mk(13,   2, 1, 1, 0, 13,  0, 1, 0));
    vecs.push_back(mk(60,   2, 1, 1, 0, 0,   4, 1, 0));
    vecs.push_back(mk(74,   2, 1, 1, 0, 14,  4, 1, 0));
    vecs.push_back(mk(75,   2, 1, 0, 0, 0,   5, 1, 0));
    vecs.push_back(mk(104,  2, 1, 0, 0, 14,  6, 1, 0));
    vecs.push_back(mk(105,  2, 1, 1, 0, 0,   7, 1, 0));
    vecs.push_back(mk(119,  2, 1, 1, 0, 14,  7, 1, 0));
    vecs.push_back(mk(120,  2, 1, 1, 1, 0,   0, 1, 1));
    vecs.push_back(mk(239,  2, 1, 1, 0, 14,  7, 1, 1));
    vecs.push_back(mk(240,  2, 1, 1, 1, 0,   0, 1, 2));
    vecs.push_back(mk(719,  0, 1, 1, 1, 719, 0, 1, 0));
    vecs.push_back(mk(720,  0, 1, 1, 0, 720, 0, 1, 0));
    vecs.push_back(mk(735,  0, 1, 1, 0, 735, 0, 1, 0));
    vecs.push_back(mk(736,  0, 0, 1, 0, 736, 0, 1, 0));
    vecs.push_back(mk(797,  0, 0, 1, 0, 797, 0, 1, 0));
    vecs.push_back(mk(798,  0, 1, 1, 0, 798, 0, 1, 0));
    vecs.push_back(mk(857,  0, 1, 1, 0, 857, 0, 1, 0));
    vecs.push_back(mk(858,  0, 1, 1, 1, 0,   1, 1, 0));
    vecs.push_back(mk(1439, 1, 1, 1, 1, 719, 0, 0, 0));
    vecs.push_back(mk(1471, 1, 1, 1, 0, 735, 0, 0, 0));
    vecs.push_back(mk(1472, 1, 0, 1, 0, 736, 0, 1, 0));
    vecs.push_back(mk(1594, 0, 0, 1, 0, 736, 1, 1, 0));
    vecs.push_back(mk(1716, 1, 1, 1, 1, 0,   1, 1, 0));
    vecs.push_back(mk(2435, 0, 1, 1, 1, 719, 2, 1, 0));

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkResetState("reset_init");
    releaseReset();
    runTable("run1");

    // Window spans default lines 4..7, div2 lines 2..3 and ~28 small frames
    run0 = 0; len0 = -1; fall0 = -1; per0 = -1; de0_cnt = 0;
    run2 = 0; len2 = -1; fall2 = -1; per2 = -1; stb2_cnt = 0; stb_err = 0; hold_err = 0;
    runs = 0; lens = -1; falls = -1; pers = -1; des_frame = 0; des_err = 0;
    applyStimulus(3431);
    p_hs0 = hs0; p_hs2 = hs2; p_vss = vss;
    p_out2 = {x2, y2, hs2, vs2, de2};
    repeat (3432) begin
      applyStimulus(cyc + 1);
      if (!hs0) run0++;
      if (!p_hs0 && hs0) begin len0 = run0; run0 = 0; end
      if (p_hs0 && !hs0) begin if (fall0 >= 0) per0 = cyc - fall0; fall0 = cyc; end
      if (de0) de0_cnt++;
      p_hs0 = hs0;

      if (!hs2) run2++;
      if (!p_hs2 && hs2) begin len2 = run2; run2 = 0; end
      if (p_hs2 && !hs2) begin if (fall2 >= 0) per2 = cyc - fall2; fall2 = cyc; end
      if (stb2) stb2_cnt++;
      if (stb2 !== (cyc % 2 == 0)) stb_err++;
      if (!stb2 && ({x2, y2, hs2, vs2, de2} !== p_out2)) hold_err++;
      p_hs2 = hs2;
      p_out2 = {x2, y2, hs2, vs2, de2};

      if (!vss) runs++;
      if (!p_vss && vss) begin lens = runs; runs = 0; end
      if (p_vss && !vss) begin if (falls >= 0) pers = cyc - falls; falls = cyc; end
      if (cyc >= 3480 && cyc < 3600 && des) des_frame++;
      if (ys >= 3'd4 && des) des_err++;
      p_vss = vss;
    end
    checkOutput("hsync_low_clocks",   64'(len0),      64'(62));
    checkOutput("line_period",        64'(per0),      64'(858));
    checkOutput("display_4_lines",    64'(de0_cnt),   64'(2880));
    checkOutput("div2_stb_alternate", 64'(stb_err),   64'(0));
    checkOutput("div2_hold_between",  64'(hold_err),  64'(0));
    checkOutput("div2_stb_count",     64'(stb2_cnt),  64'(1716));
    checkOutput("div2_hsync_clocks",  64'(len2),      64'(124));
    checkOutput("div2_line_period",   64'(per2),      64'(1716));
    checkOutput("small_vsync_clocks", 64'(lens),      64'(30));
    checkOutput("small_frame_period", 64'(pers),      64'(120));
    checkOutput("small_display_frm",  64'(des_frame), 64'(32));
    checkOutput("small_blank_lines",  64'(des_err),   64'(0));

    // Mid-line reset: default at x=300 on line 8, div2 mid-pixel, small inside vsync
    applyStimulus(7164);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("reset_mid");
    releaseReset();
    runTable("run2");

`ifdef VGA_FRAME_COUNT_EN
    applyStimulus(30719);
    checkOutput("frame_255",       64'(fns), 64'(255));
    applyStimulus(30720);
    checkOutput("frame_wrap_0",    64'(fns), 64'(0));
    checkOutput("frame_wrap_pos",  pack(hss, vss, des, stbs, int'(xs), int'(ys)), pack(1, 1, 1, 1, 0, 0));
    checkOutput("frame_dut_first", 64'(fn0), 64'(0));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter H_DISPLAY, default 720, visible pixels per line.
REQ-002 The module SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 62, hsync pulse width in pixels.
REQ-004 The module SHALL have parameter H_BACK, default 60, horizontal back porch in pixels.
REQ-005 The module SHALL have parameters V_DISPLAY 480, V_FRONT 9, V_SYNC 6 and V_BACK 30, the vertical equivalents in lines.
REQ-006 The module SHALL have parameter CLK_DIV, default 1, clocks per pixel (1..16).
REQ-007 The module SHALL have port clk, input, 1, the single clock.
REQ-008 The module SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 The module SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-010 The module SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-011 The module SHALL have port display_on, output, 1, high when the pixel is in the visible area.
REQ-012 The module SHALL have port x, output, $clog2(H_TOTAL), current pixel column.
REQ-013 The module SHALL have port y, output, $clog2(V_TOTAL), current line.
REQ-014 The module SHALL have port pixel_stb, output, 1, one-clock strobe marking each new pixel.

Function
REQ-015 H_TOTAL SHALL be H_DISPLAY+H_FRONT+H_SYNC+H_BACK (858 by default), and V_TOTAL SHALL be the vertical sum (525 by default).
REQ-016 A divider SHALL assert pixel_stb on one clock out of every CLK_DIV clocks; with CLK_DIV=1 it SHALL be high on every clock after reset.
REQ-017 h_cnt SHALL increment on each strobe and wrap from H_TOTAL-1 to 0.
REQ-018 v_cnt SHALL increment only on a strobe where h_cnt wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same strobe.
REQ-019 hsync SHALL be low while H_DISPLAY+H_FRONT <= h_cnt < H_DISPLAY+H_FRONT+H_SYNC.
REQ-020 vsync SHALL be low while V_DISPLAY+V_FRONT <= v_cnt < V_DISPLAY+V_FRONT+V_SYNC.
REQ-021 display_on SHALL be high iff h_cnt < H_DISPLAY and v_cnt < V_DISPLAY.
REQ-022 All outputs SHALL be registered and lag the counters by exactly 1 clock, so hsync, vsync, display_on, x and y stay mutually aligned.
REQ-023 Counter widths SHALL come from $clog2 of the totals, with no truncation at the maximum count.

Reset
REQ-024 While rst is high, the outputs SHALL be: hsync=1, vsync=1, display_on=0, x=0, y=0 and pixel_stb=0; the counters and the divider SHALL be 0.
REQ-025 A reset asserted mid-line or mid-frame SHALL take effect on the next clock edge and leave no residual state.
REQ-026 After reset is released, counting SHALL restart at h_cnt=0 and v_cnt=0, and the first strobe SHALL occur on the first clock of the divider cycle.

Configuration
REQ-027 When the macro VGA_FRAME_COUNT_EN is defined, the module SHALL add output frame_num, 8 bits, which increments (mod 256) in the clock after the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), and which reset clears to 0.
REQ-028 When VGA_FRAME_COUNT_EN is not defined, the frame_num port and its logic SHALL be absent.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the default timing constants for 720x480@60 at 27 MHz and a 640x480@60 set for 25 MHz boards.
REQ-030 The pixel strobe divider SHALL be a sub-module named vga_pixel_strobe.
REQ-031 The board top SHALL map the colour bits to GPIO; this block SHALL produce timing only.

Verification
REQ-032 The bench SHALL check default parameters, CLK_DIV=1: hsync low for exactly 62 clocks, starting 1 clock after h_cnt=736; line period 858 clocks.
REQ-033 The bench SHALL check default parameters: vsync low for exactly 6 lines (v_cnt 489..494); frame period 450450 clocks.
REQ-034 The bench SHALL check display_on: 720 clocks high per visible line, 0 on lines 480..524, and x=719 on the last visible pixel.
REQ-035 The bench SHALL check CLK_DIV=2: pixel_stb on alternate clocks; line period 1716 clocks; outputs stable between strobes.
REQ-036 The bench SHALL apply rst at h_cnt=300, v_cnt=100 and check: next clock hsync=1, vsync=1, display_on=0, x=0, y=0; after release, the timing of REQ-032 repeats from 0.
REQ-037 The bench SHALL check, with VGA_FRAME_COUNT_EN defined: frame_num=2 after 2×450450 clocks, and wrap from 255 to 0 on frame 256.
